memoria_instr_sinc: RTL and testbench

//  Parametrised synchronous instruction memory, successor to the combinational ROM.
//  Has a program-load port and a registered fetch port with request, stall and valid.

---
 rtl/memoria_instr_sinc.sv | 140 ++++++++++++++
 tb/tb_memoria_instr_sinc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_instr_sinc.sv
// Synchronous instruction memory: program-load port filled once after reset,
// then a read-only registered fetch port with request, stall and valid.
module memoria_instr_sinc #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_done,
    output logic [ADDR_W:0]   prog_count,
    output logic              running,
    input  logic              rd_req,
    input  logic [ADDR_W+1:0] rd_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              misalign
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W:0]   prog_count_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] instr_r;
    logic              instr_valid_r;
    logic              misalign_r;

    logic              load_wr_s;
    logic              fetch_s;
    logic              hold_s;
    logic [ADDR_W-1:0] idx_s;
    logic              misalign_s;
    logic [DATA_W-1:0] fetch_word_s;

    // Next-state and load/fetch acceptance decode
    always_comb begin
        state_s   = state_r;
        load_wr_s = 1'b0;
        fetch_s   = 1'b0;
        hold_s    = 1'b1;
        case (state_r)
            ST_LOAD: begin
                if (prog_we && (prog_count_r < DEPTH_CNT)) begin
                    load_wr_s = 1'b1;
                end else begin
                    load_wr_s = 1'b0;
                end
                if (prog_done) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                hold_s  = stall;
                if (rd_req && !stall) begin
                    fetch_s = 1'b1;
                end else begin
                    fetch_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // Fetch word selection; words at or beyond the load count read as NOP
    always_comb begin
        idx_s      = rd_addr[ADDR_W+1:2];
        misalign_s = |rd_addr[1:0];
        if (misalign_s || ({1'b0, idx_s} >= prog_count_r)) begin
            fetch_word_s = NOP;
        end else begin
            fetch_word_s = mem_r[idx_s];
        end
    end

    // FSM state and load pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_LOAD;
            prog_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            state_r <= state_s;
            if (load_wr_s) begin
                prog_count_r <= prog_count_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                prog_count_r <= prog_count_r;
            end
        end
    end

    // Storage array is deliberately left uncleared by reset; the count gates it
    always_ff @(posedge clk) begin
        if (load_wr_s) begin
            mem_r[prog_count_r[ADDR_W-1:0]] <= prog_data;
        end
    end

    // Registered fetch outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r       <= NOP;
            instr_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else if (fetch_s) begin
            instr_r       <= fetch_word_s;
            instr_valid_r <= 1'b1;
            misalign_r    <= misalign_s;
        end else if (!hold_s) begin
            instr_r       <= instr_r;
            instr_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            instr_r       <= instr_r;
            instr_valid_r <= instr_valid_r;
            misalign_r    <= misalign_r;
        end
    end

    assign prog_count  = prog_count_r;
    assign running     = (state_r == ST_RUN);
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign misalign    = misalign_r;

endmodule

// File: tb/tb_memoria_instr_sinc.sv
// Scoreboard bench for memoria_instr_sinc: a 64-word instance for load/fetch/
// stall/reset behaviour and a 4-word instance for load-pointer saturation.
module tb_memoria_instr_sinc;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [31:0] prog_data;
    logic        prog_done;
    logic [6:0]  prog_count;
    logic        running;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign;

    logic        s_prog_we;
    logic [31:0] s_prog_data;
    logic        s_prog_done;
    logic [2:0]  s_prog_count;
    logic        s_running;
    logic        s_rd_req;
    logic [3:0]  s_rd_addr;
    logic        s_stall;
    logic [31:0] s_instr;
    logic        s_instr_valid;
    logic        s_misalign;

    memoria_instr_sinc #(.ADDR_W(6), .DATA_W(32), .NOP(NOP)) u_dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_data(prog_data),
        .prog_done(prog_done), .prog_count(prog_count), .running(running),
        .rd_req(rd_req), .rd_addr(rd_addr), .stall(stall), .instr(instr),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    memoria_instr_sinc #(.ADDR_W(2), .DATA_W(32), .NOP(NOP)) u_sat (
        .clk(clk), .rst(rst), .prog_we(s_prog_we), .prog_data(s_prog_data),
        .prog_done(s_prog_done), .prog_count(s_prog_count), .running(s_running),
        .rd_req(s_rd_req), .rd_addr(s_rd_addr), .stall(s_stall), .instr(s_instr),
        .instr_valid(s_instr_valid), .misalign(s_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // reference model of the memory and fetch outputs
    logic [31:0] tb_mem [64];
    int          tb_cnt;
    logic        tb_run;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tb_cnt  = 0;
        tb_run  = 1'b0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        sb_q.delete();
    endtask

    // drive one fetch-port cycle, push the model's expectation, compare after the edge
    task automatic cycle(input string tag, input logic req, input logic [7:0] addr, input logic stl);
        exp_t e;
        int   idx;
        rd_req  = req;
        rd_addr = addr;
        stall   = stl;
        if (tb_run && !stl) begin
            if (req) begin
                idx     = int'(addr[7:2]);
                m_mis   = |addr[1:0];
                m_instr = (m_mis || idx >= tb_cnt) ? NOP : tb_mem[idx];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_mis   = 1'b0;
            end
        end
        e.instr = m_instr;
        e.valid = m_valid;
        e.mis   = m_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_instr"}, instr, e.instr);
            check({tag, "_valid"}, 32'(instr_valid), 32'(e.valid));
            check({tag, "_mis"}, 32'(misalign), 32'(e.mis));
        end
        rd_req = 1'b0;
        stall  = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] data, input logic done);
        prog_we   = 1'b1;
        prog_data = data;
        prog_done = done;
        if (!tb_run && tb_cnt < 64) begin
            tb_mem[tb_cnt] = data;
            tb_cnt++;
        end
        if (done) tb_run = 1'b1;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
        prog_done = 1'b0;
    endtask

    task automatic finish_load();
        prog_done = 1'b1;
        tb_run    = 1'b1;
        @(posedge clk);
        #1;
        prog_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        prog_we = 1'b0; prog_data = 32'd0; prog_done = 1'b0;
        rd_req = 1'b0; rd_addr = 8'd0; stall = 1'b0;
        s_prog_we = 1'b0; s_prog_data = 32'd0; s_prog_done = 1'b0;
        s_rd_req = 1'b0; s_rd_addr = 4'd0; s_stall = 1'b0;
        model_reset();
        #2;
        check("rst_count", 32'(prog_count), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1 load
        load_word(32'h20080005, 1'b0);
        load_word(32'h20090003, 1'b0);
        load_word(32'h01095020, 1'b0);
        load_word(32'hAC0A0000, 1'b0);
        check("t1_count", 32'(prog_count), 32'd4);
        check("t1_not_running", 32'(running), 32'd0);
        finish_load();
        check("t1_running", 32'(running), 32'd1);
        check("t1_count_run", 32'(prog_count), 32'd4);

        // RUN ignores load port
        prog_we = 1'b1; prog_data = 32'hFFFFFFFF; prog_done = 1'b1;
        cycle("ro_a0", 1'b1, 8'd0, 1'b0);
        prog_we = 1'b0; prog_done = 1'b0;
        check("ro_count", 32'(prog_count), 32'd4);

        // T2 back-to-back fetch
        for (int i = 0; i < 4; i++) cycle("t2_fetch", 1'b1, 8'(i * 4), 1'b0);

        // T3 invalid and misaligned
        cycle("t3_a16", 1'b1, 8'd16, 1'b0);
        cycle("t3_a252", 1'b1, 8'd252, 1'b0);
        cycle("t3_a6", 1'b1, 8'd6, 1'b0);
        cycle("t3_stall_mis", 1'b0, 8'd0, 1'b1);
        cycle("t3_idle", 1'b0, 8'd0, 1'b0);

        // T4 stall
        cycle("t4_a4", 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 3; i++) cycle("t4_stall", 1'b1, 8'd8, 1'b1);
        cycle("t4_a8", 1'b1, 8'd8, 1'b0);
        cycle("t4_idle", 1'b0, 8'd0, 1'b0);

        // T6 async reset mid-fetch
        cycle("t6_a0", 1'b1, 8'd0, 1'b0);
        rd_req = 1'b1; rd_addr = 8'd4;
        #3;
        rst = 1'b1;
        #1;
        check("t6_instr", instr, NOP);
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_running", 32'(running), 32'd0);
        check("t6_count", 32'(prog_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; rd_req = 1'b0;
        cycle("t6_load_req", 1'b1, 8'd0, 1'b0);
        finish_load();
        check("t6_running_empty", 32'(running), 32'd1);
        cycle("t6_empty_a0", 1'b1, 8'd0, 1'b0);

        // write together with prog_done is accepted
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_word(32'hDEADBEEF, 1'b1);
        check("wd_count", 32'(prog_count), 32'd1);
        check("wd_running", 32'(running), 32'd1);
        cycle("wd_a0", 1'b1, 8'd0, 1'b0);
        cycle("wd_a4", 1'b1, 8'd4, 1'b0);

        // T5 saturation on the 4-word instance
        s_rd_req = 1'b1; s_rd_addr = 4'd0;
        for (int i = 0; i < 6; i++) begin
            s_prog_we = 1'b1;
            s_prog_data = 32'h100 + 32'(i);
            @(posedge clk);
            #1;
        end
        s_prog_we = 1'b0;
        check("t5_count", 32'(s_prog_count), 32'd4);
        check("t5_load_valid", 32'(s_instr_valid), 32'd0);
        check("t5_load_instr", s_instr, NOP);
        check("t5_not_running", 32'(s_running), 32'd0);
        s_rd_req = 1'b0; s_prog_done = 1'b1;
        @(posedge clk);
        #1;
        s_prog_done = 1'b0;
        s_rd_req = 1'b1; s_rd_addr = 4'd12;
        @(posedge clk);
        #1;
        check("t5_a12", s_instr, 32'h103);
        s_rd_addr = 4'd0;
        @(posedge clk);
        #1;
        check("t5_a0", s_instr, 32'h100);
        check("t5_valid", 32'(s_instr_valid), 32'd1);
        s_rd_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
